// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard/stall controller:
// ID decode and EX branch resolution in, fetch/pipeline controls and counters out.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic             id_invalid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       id_rd;
    logic             id_reg_write;
    logic             id_is_load;
    logic             branch_taken;
    logic             dmem_busy;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             pipe_freeze;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Datapath side.
    modport master (
        output id_valid, id_invalid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_is_load, branch_taken, dmem_busy,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze,
               stall_cnt, flush_cnt
    );

    // Controller side.
    modport slave (
        input  id_valid, id_invalid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_is_load, branch_taken, dmem_busy,
        output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage core: tracks in-flight destinations
// in EX and MEM and decides freeze / flush / stall / run in the same cycle.
module hazard_stall_ctrl #(
    parameter bit FORWARDING = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_STALL,
        MODE_FLUSH,
        MODE_FREEZE
    } mode_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       is_load;
    } slot_t;

    slot_t            ex_q;
    slot_t            mem_q;
    slot_t            ex_next;
    mode_e            mode;
    logic             idq;
    logic             ex_hit;
    logic             mem_hit;
    logic             hazard;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    function automatic logic raw_hit(slot_t s, logic [4:0] rs1, logic use1,
                                     logic [4:0] rs2, logic use2);
        return s.valid && s.reg_write && (s.rd != 5'd0) &&
               ((use1 && (rs1 == s.rd)) || (use2 && (rs2 == s.rd)));
    endfunction

    assign idq     = bus.id_valid & ~bus.id_invalid;
    assign ex_hit  = raw_hit(ex_q, bus.id_rs1, bus.id_use_rs1, bus.id_rs2, bus.id_use_rs2);
    assign mem_hit = raw_hit(mem_q, bus.id_rs1, bus.id_use_rs1, bus.id_rs2, bus.id_use_rs2);

    // With forwarding, only a load still in EX cannot hand its result over in time.
    assign hazard = FORWARDING ? (ex_hit & ex_q.is_load) : (ex_hit | mem_hit);

    always_comb begin
        mode = MODE_RUN;
        if (bus.dmem_busy)         mode = MODE_FREEZE;
        else if (bus.branch_taken) mode = MODE_FLUSH;
        else if (idq && hazard)    mode = MODE_STALL;
    end

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        bus.pc_write    = 1'b1;
        bus.ifid_write  = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_bubble = 1'b0;
        bus.pipe_freeze = 1'b0;
        case (mode)
            MODE_FREEZE: begin
                bus.pc_write    = 1'b0;
                bus.ifid_write  = 1'b0;
                bus.pipe_freeze = 1'b1;
            end
            MODE_FLUSH: begin
                bus.ifid_flush  = 1'b1;
                bus.idex_bubble = 1'b1;
            end
            MODE_STALL: begin
                bus.pc_write    = 1'b0;
                bus.ifid_write  = 1'b0;
                bus.idex_bubble = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
            bus.pipe_freeze = 1'b0;
        end
    end

    always_comb begin
        ex_next = '0;
        if (mode == MODE_RUN) begin
            ex_next.valid     = idq;
            ex_next.rd        = bus.id_rd;
            ex_next.reg_write = bus.id_reg_write & idq;
            ex_next.is_load   = bus.id_is_load & idq;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (mode != MODE_FREEZE) begin
                mem_q <= ex_q;
                ex_q  <= ex_next;
            end
            if ((mode == MODE_FREEZE || mode == MODE_STALL) && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
            if ((mode == MODE_FLUSH) && (flush_q != '1))
                flush_q <= flush_q + 1'b1;
        end
    end

    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: three instances (forwarding, no forwarding, 2-bit counters)
// share one stimulus stream and are compared every cycle against an instruction-history model.
module tb_hazard_stall_ctrl;
    logic       clk;
    logic       rst;
    logic       id_valid;
    logic       id_invalid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_is_load;
    logic       branch_taken;
    logic       dmem_busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Control vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze}
    localparam logic [4:0] CTL_RUN    = 5'b11000;
    localparam logic [4:0] CTL_STALL  = 5'b00010;
    localparam logic [4:0] CTL_FLUSH  = 5'b11110;
    localparam logic [4:0] CTL_FREEZE = 5'b00001;
    localparam logic [4:0] CTL_RESET  = 5'b00110;

    localparam int M_RUN = 0, M_STALL = 1, M_FLUSH = 2, M_FREEZE = 3;
    localparam bit FWD [3] = '{1'b1, 1'b0, 1'b1};
    localparam int CW  [3] = '{16, 16, 2};

    hazard_stall_ctrl_if #(.CNT_W(16)) if_fwd ();
    hazard_stall_ctrl_if #(.CNT_W(16)) if_nofwd ();
    hazard_stall_ctrl_if #(.CNT_W(2))  if_sat ();

    hazard_stall_ctrl #(.FORWARDING(1'b1), .CNT_W(16)) u_fwd   (.clk(clk), .rst(rst), .bus(if_fwd));
    hazard_stall_ctrl #(.FORWARDING(1'b0), .CNT_W(16)) u_nofwd (.clk(clk), .rst(rst), .bus(if_nofwd));
    hazard_stall_ctrl #(.FORWARDING(1'b1), .CNT_W(2))  u_sat   (.clk(clk), .rst(rst), .bus(if_sat));

    assign if_fwd.id_valid       = id_valid;
    assign if_fwd.id_invalid     = id_invalid;
    assign if_fwd.id_rs1         = id_rs1;
    assign if_fwd.id_rs2         = id_rs2;
    assign if_fwd.id_use_rs1     = id_use_rs1;
    assign if_fwd.id_use_rs2     = id_use_rs2;
    assign if_fwd.id_rd          = id_rd;
    assign if_fwd.id_reg_write   = id_reg_write;
    assign if_fwd.id_is_load     = id_is_load;
    assign if_fwd.branch_taken   = branch_taken;
    assign if_fwd.dmem_busy      = dmem_busy;

    assign if_nofwd.id_valid     = id_valid;
    assign if_nofwd.id_invalid   = id_invalid;
    assign if_nofwd.id_rs1       = id_rs1;
    assign if_nofwd.id_rs2       = id_rs2;
    assign if_nofwd.id_use_rs1   = id_use_rs1;
    assign if_nofwd.id_use_rs2   = id_use_rs2;
    assign if_nofwd.id_rd        = id_rd;
    assign if_nofwd.id_reg_write = id_reg_write;
    assign if_nofwd.id_is_load   = id_is_load;
    assign if_nofwd.branch_taken = branch_taken;
    assign if_nofwd.dmem_busy    = dmem_busy;

    assign if_sat.id_valid       = id_valid;
    assign if_sat.id_invalid     = id_invalid;
    assign if_sat.id_rs1         = id_rs1;
    assign if_sat.id_rs2         = id_rs2;
    assign if_sat.id_use_rs1     = id_use_rs1;
    assign if_sat.id_use_rs2     = id_use_rs2;
    assign if_sat.id_rd          = id_rd;
    assign if_sat.id_reg_write   = id_reg_write;
    assign if_sat.id_is_load     = id_is_load;
    assign if_sat.branch_taken   = branch_taken;
    assign if_sat.dmem_busy      = dmem_busy;

    logic [2:0][4:0]  dut_ctl;
    logic [2:0][15:0] dut_stall;
    logic [2:0][15:0] dut_flush;

    assign dut_ctl[0]   = {if_fwd.pc_write, if_fwd.ifid_write, if_fwd.ifid_flush,
                           if_fwd.idex_bubble, if_fwd.pipe_freeze};
    assign dut_ctl[1]   = {if_nofwd.pc_write, if_nofwd.ifid_write, if_nofwd.ifid_flush,
                           if_nofwd.idex_bubble, if_nofwd.pipe_freeze};
    assign dut_ctl[2]   = {if_sat.pc_write, if_sat.ifid_write, if_sat.ifid_flush,
                           if_sat.idex_bubble, if_sat.pipe_freeze};
    assign dut_stall[0] = if_fwd.stall_cnt;
    assign dut_stall[1] = if_nofwd.stall_cnt;
    assign dut_stall[2] = {14'd0, if_sat.stall_cnt};
    assign dut_flush[0] = if_fwd.flush_cnt;
    assign dut_flush[1] = if_nofwd.flush_cnt;
    assign dut_flush[2] = {14'd0, if_sat.flush_cnt};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: the instructions issued into EX over the last two cycles
    // (age 0 = issued last cycle, now in EX; age 1 = issued two cycles ago, now in MEM),
    // plus plain integer event counts capped when compared.
    bit         h_v  [3][2];
    logic [4:0] h_rd [3][2];
    bit         h_wr [3][2];
    bit         h_ld [3][2];
    int         m_stall [3];
    int         m_flush [3];
    bit         known [3] = '{1'b0, 1'b0, 1'b0};

    function automatic bit reads_reg(logic [4:0] r);
        return (r != 5'd0) &&
               ((id_use_rs1 && (id_rs1 == r)) || (id_use_rs2 && (id_rs2 == r)));
    endfunction

    function automatic bit model_hazard(int k);
        bit h;
        h = 1'b0;
        for (int age = 0; age < 2; age++) begin
            if (h_v[k][age] && h_wr[k][age] && reads_reg(h_rd[k][age])) begin
                if (!FWD[k]) h = 1'b1;
                else if (age == 0 && h_ld[k][age]) h = 1'b1;
            end
        end
        return h;
    endfunction

    function automatic int model_mode(int k);
        if (dmem_busy) return M_FREEZE;
        if (branch_taken) return M_FLUSH;
        if (id_valid && !id_invalid && model_hazard(k)) return M_STALL;
        return M_RUN;
    endfunction

    task automatic issue(int k, bit v, logic [4:0] rd, bit wr, bit ld);
        h_v[k][1]  = h_v[k][0];
        h_rd[k][1] = h_rd[k][0];
        h_wr[k][1] = h_wr[k][0];
        h_ld[k][1] = h_ld[k][0];
        h_v[k][0]  = v;
        h_rd[k][0] = rd;
        h_wr[k][0] = wr;
        h_ld[k][0] = ld;
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int         mode;
            int         cap;
            logic [4:0] exp_ctl;
            bit         idq;
            idq  = id_valid && !id_invalid;
            mode = model_mode(k);
            cap  = (1 << CW[k]) - 1;
            case (mode)
                M_FREEZE: exp_ctl = CTL_FREEZE;
                M_FLUSH:  exp_ctl = CTL_FLUSH;
                M_STALL:  exp_ctl = CTL_STALL;
                default:  exp_ctl = CTL_RUN;
            endcase
            if (rst) exp_ctl = CTL_RESET;
            if (rst || known[k])
                check($sformatf("ctl[%0d]", k), 32'(dut_ctl[k]), 32'(exp_ctl));
            if (known[k]) begin
                check($sformatf("stall_cnt[%0d]", k), 32'(dut_stall[k]),
                      32'((m_stall[k] > cap) ? cap : m_stall[k]));
                check($sformatf("flush_cnt[%0d]", k), 32'(dut_flush[k]),
                      32'((m_flush[k] > cap) ? cap : m_flush[k]));
            end
            if (rst) begin
                for (int a = 0; a < 2; a++) begin
                    h_v[k][a] = 1'b0; h_rd[k][a] = 5'd0; h_wr[k][a] = 1'b0; h_ld[k][a] = 1'b0;
                end
                m_stall[k] = 0;
                m_flush[k] = 0;
                known[k]   = 1'b1;
            end else if (known[k]) begin
                case (mode)
                    M_FREEZE: m_stall[k]++;
                    M_FLUSH: begin
                        issue(k, 1'b0, 5'd0, 1'b0, 1'b0);
                        m_flush[k]++;
                    end
                    M_STALL: begin
                        issue(k, 1'b0, 5'd0, 1'b0, 1'b0);
                        m_stall[k]++;
                    end
                    default: issue(k, idq, id_rd, id_reg_write && idq, id_is_load && idq);
                endcase
            end
        end
    end

    task automatic idle();
        id_valid = 1'b0; id_invalid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_rd = 5'd0; id_reg_write = 1'b0;
        id_is_load = 1'b0; branch_taken = 1'b0; dmem_busy = 1'b0;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic wr, input logic ld);
        id_valid = 1'b1; id_invalid = 1'b0;
        id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = wr; id_is_load = ld;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) begin
            to_sample(); check("reset_ctl", 32'(dut_ctl[0]), 32'(CTL_RESET)); to_drive();
        end
        rst = 1'b0;
        to_sample();
        check("first_run", 32'(dut_ctl[0]), 32'(CTL_RUN));
        check("reset_stall_cnt", 32'(dut_stall[0]), 32'd0);
        to_drive();

        // lw x5 then add x6,x5,x7
        set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        to_sample(); check("lw_issue", 32'(dut_ctl[0]), 32'(CTL_RUN)); to_drive();
        set_id(5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0);
        to_sample();
        check("loaduse_stall_fwd", 32'(dut_ctl[0]), 32'(CTL_STALL));
        check("loaduse_stall_nofwd", 32'(dut_ctl[1]), 32'(CTL_STALL));
        to_drive();
        to_sample();
        check("loaduse_resume_fwd", 32'(dut_ctl[0]), 32'(CTL_RUN));
        check("raw_second_stall_nofwd", 32'(dut_ctl[1]), 32'(CTL_STALL));
        check("loaduse_stall_cnt", 32'(dut_stall[0]), 32'd1);
        to_drive();
        to_sample();
        check("nofwd_resume", 32'(dut_ctl[1]), 32'(CTL_RUN));
        check("nofwd_stall_cnt_2", 32'(dut_stall[1]), 32'd2);
        check("fwd_stall_cnt_hold", 32'(dut_stall[0]), 32'd1);
        to_drive();

        // add x3; independent add x9; sub x4,x3,x1
        set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        to_sample(); check("add_x3", 32'(dut_ctl[1]), 32'(CTL_RUN)); to_drive();
        set_id(5'd10, 1'b1, 5'd11, 1'b1, 5'd9, 1'b1, 1'b0);
        to_sample(); check("indep_add", 32'(dut_ctl[1]), 32'(CTL_RUN)); to_drive();
        set_id(5'd3, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0);
        to_sample();
        check("gap_stall_nofwd", 32'(dut_ctl[1]), 32'(CTL_STALL));
        check("gap_run_fwd", 32'(dut_ctl[0]), 32'(CTL_RUN));
        to_drive();
        to_sample();
        check("gap_resume_nofwd", 32'(dut_ctl[1]), 32'(CTL_RUN));
        check("gap_stall_cnt", 32'(dut_stall[1]), 32'd3);
        to_drive();

        // lw x0 / add x1,x0,x0; lw x5 / addi x7,x2 with rs2=x5 unused
        set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        to_drive();
        set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0);
        to_sample(); check("x0_no_stall", 32'(dut_ctl[0]), 32'(CTL_RUN)); to_drive();
        set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        to_drive();
        set_id(5'd2, 1'b1, 5'd5, 1'b0, 5'd7, 1'b1, 1'b0);
        to_sample(); check("unused_rs2_no_stall", 32'(dut_ctl[0]), 32'(CTL_RUN)); to_drive();

        // lw x8, then taken branch with a hazarding add in ID
        set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
        to_drive();
        set_id(5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
        branch_taken = 1'b1;
        to_sample(); check("branch_flush", 32'(dut_ctl[0]), 32'(CTL_FLUSH)); to_drive();
        branch_taken = 1'b0;
        set_id(5'd9, 1'b1, 5'd8, 1'b1, 5'd10, 1'b1, 1'b0);
        to_sample();
        check("after_flush_run", 32'(dut_ctl[0]), 32'(CTL_RUN));
        check("flush_cnt_1", 32'(dut_flush[0]), 32'd1);
        to_drive();

        // reset asserted during a load-use stall
        set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        to_drive();
        set_id(5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0);
        rst = 1'b1;
        to_sample(); check("rst_mid_stall", 32'(dut_ctl[0]), 32'(CTL_RESET)); to_drive();
        rst = 1'b0;
        to_sample();
        check("post_rst_run", 32'(dut_ctl[0]), 32'(CTL_RUN));
        check("post_rst_stall_cnt", 32'(dut_stall[0]), 32'd0);
        check("post_rst_flush_cnt", 32'(dut_flush[0]), 32'd0);
        to_drive();

        // freeze with a pending branch for 3 cycles, then the flush
        idle();
        dmem_busy = 1'b1;
        branch_taken = 1'b1;
        repeat (3) begin
            to_sample(); check("freeze", 32'(dut_ctl[0]), 32'(CTL_FREEZE)); to_drive();
        end
        dmem_busy = 1'b0;
        to_sample(); check("flush_after_freeze", 32'(dut_ctl[0]), 32'(CTL_FLUSH)); to_drive();
        branch_taken = 1'b0;
        to_sample();
        check("freeze_stall_cnt", 32'(dut_stall[0]), 32'd3);
        check("freeze_flush_cnt", 32'(dut_flush[0]), 32'd1);
        to_drive();

        // saturation of the 2-bit counters
        rst = 1'b1;
        to_drive();
        rst = 1'b0;
        dmem_busy = 1'b1;
        repeat (6) to_drive();
        dmem_busy = 1'b0;
        to_sample();
        check("sat_stall_cnt", 32'(dut_stall[2]), 32'd3);
        check("wide_stall_cnt", 32'(dut_stall[0]), 32'd6);
        to_drive();

        // randomized traffic over a small register set to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(63) == 0);
            id_valid     = ($urandom_range(7) != 0);
            id_invalid   = ($urandom_range(9) == 0);
            id_rs1       = 5'($urandom_range(3));
            id_rs2       = 5'($urandom_range(3));
            id_use_rs1   = ($urandom_range(3) != 0);
            id_use_rs2   = ($urandom_range(3) != 0);
            id_rd        = 5'($urandom_range(3));
            id_reg_write = ($urandom_range(4) != 0);
            id_is_load   = ($urandom_range(2) == 0);
            branch_taken = ($urandom_range(7) == 0);
            dmem_busy    = ($urandom_range(7) == 0);
            to_drive();
        end
        rst = 1'b0;
        idle();
        repeat (3) to_drive();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
